// File: rtl/tri_area_recip_pipe.sv
// Triangle doubled-area edge function plus saturated fixed-point reciprocal; optional TRI_AREA_CULL_EN drops area2<=0.
// Latency: 4 edges from accept for degenerate triangles, 4+D otherwise (D = OUT_FRAC+2*FRAC+1).
// Backpressure: one triangle in flight; in_ready only in IDLE, result holds in OUT until out_ready.
module tri_area_recip_pipe #(
  parameter int W        = 16,
  parameter int FRAC     = 4,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 12,
  parameter int TAG_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         v0x,
  input  logic [W-1:0]         v0y,
  input  logic [W-1:0]         v1x,
  input  logic [W-1:0]         v1y,
  input  logic [W-1:0]         v2x,
  input  logic [W-1:0]         v2y,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*W+2:0]       area2,
  output logic [OUT_W-1:0]     recip,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 degenerate,
  output logic                 backface,
  output logic                 sat
);

  localparam int AW = 2*W+3;
  localparam int RW = AW+1;
  localparam int D  = OUT_FRAC+2*FRAC+1;
  localparam int CW = $clog2(D+1);
  localparam int QW = (D > OUT_W) ? D : OUT_W;
  localparam logic [QW-1:0] QMAX    = QW'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic [CW-1:0] CNT_TOP = CW'(D-1);

  typedef enum logic [2:0] {IDLE, SUB, MUL0, MUL1, SUM, DIV, OUT} state_t;
  state_t state_q, state_d;

  logic signed [W-1:0]   v0x_q, v0y_q, v1x_q, v1y_q, v2x_q, v2y_q;
  logic signed [W:0]     dx1_q, dy2_q, dy1_q, dx2_q;
  logic signed [W:0]     mul_a, mul_b;
  logic signed [2*W+1:0] prod, p0_q, p1_q;
  logic signed [AW-1:0]  sum_c;
  logic [AW-1:0]         abs_c;
  logic                  area_zero, drop_c;

  logic [AW-1:0]         den_q, rem_q, rem_nx;
  logic [RW-1:0]         rem_sh;
  logic [D-1:0]          quo_q, quo_nx;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q, rem_ge, sat_c;
  logic [QW-1:0]         q_ext;
  logic [OUT_W-1:0]      mag_c, recip_c;

  // One multiplier shared across MUL0 (dx1*dy2) and MUL1 (dy1*dx2).
  always_comb begin
    mul_a = (state_q == MUL1) ? dy1_q : dx1_q;
    mul_b = (state_q == MUL1) ? dx2_q : dy2_q;
    prod  = (2*W+2)'(mul_a) * (2*W+2)'(mul_b);
    sum_c = AW'(p0_q) - AW'(p1_q);
    abs_c = sum_c[AW-1] ? $unsigned(-sum_c) : $unsigned(sum_c);
    area_zero = (sum_c == '0);
`ifdef TRI_AREA_CULL_EN
    drop_c = sum_c[AW-1] | area_zero;
`else
    drop_c = 1'b0;
`endif
  end

  // Restoring division of the constant 2^(D-1): the only set dividend bit enters first.
  always_comb begin
    rem_sh  = {rem_q, (cnt_q == CNT_TOP)};
    rem_ge  = (rem_sh >= {1'b0, den_q});
    rem_nx  = AW'(rem_ge ? (rem_sh - {1'b0, den_q}) : rem_sh);
    quo_nx  = {quo_q[D-2:0], rem_ge};
    q_ext   = QW'(quo_nx);
    sat_c   = (q_ext > QMAX);
    mag_c   = sat_c ? QMAX[OUT_W-1:0] : q_ext[OUT_W-1:0];
    recip_c = neg_q ? (~mag_c + 1'b1) : mag_c;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) state_d = SUB;
      SUB:  state_d = MUL0;
      MUL0: state_d = MUL1;
      MUL1: state_d = SUM;
      SUM: begin
        if (drop_c)         state_d = IDLE;
        else if (area_zero) state_d = OUT;
        else                state_d = DIV;
      end
      DIV:  if (cnt_q == '0) state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      area2      <= '0;
      recip      <= '0;
      out_tag    <= '0;
      degenerate <= 1'b0;
      backface   <= 1'b0;
      sat        <= 1'b0;
      v0x_q <= '0; v0y_q <= '0; v1x_q <= '0; v1y_q <= '0; v2x_q <= '0; v2y_q <= '0;
      dx1_q <= '0; dy2_q <= '0; dy1_q <= '0; dx2_q <= '0;
      p0_q  <= '0; p1_q  <= '0;
      den_q <= '0; rem_q <= '0; quo_q <= '0; cnt_q <= '0; neg_q <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == OUT);
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          v0x_q <= v0x; v0y_q <= v0y; v1x_q <= v1x;
          v1y_q <= v1y; v2x_q <= v2x; v2y_q <= v2y;
          out_tag <= in_tag;
        end
        SUB: begin
          dx1_q <= {v1x_q[W-1], v1x_q} - {v0x_q[W-1], v0x_q};
          dy2_q <= {v2y_q[W-1], v2y_q} - {v0y_q[W-1], v0y_q};
          dy1_q <= {v1y_q[W-1], v1y_q} - {v0y_q[W-1], v0y_q};
          dx2_q <= {v2x_q[W-1], v2x_q} - {v0x_q[W-1], v0x_q};
        end
        MUL0: p0_q <= prod;
        MUL1: p1_q <= prod;
        SUM: begin
          area2 <= sum_c;
`ifdef TRI_AREA_CULL_EN
          backface   <= 1'b0;
          degenerate <= 1'b0;
`else
          backface   <= sum_c[AW-1];
          degenerate <= area_zero;
`endif
          neg_q <= sum_c[AW-1];
          den_q <= abs_c;
          rem_q <= '0;
          quo_q <= '0;
          cnt_q <= CNT_TOP;
          recip <= '0;
          sat   <= 1'b0;
        end
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            recip <= recip_c;
            sat   <= sat_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_area_recip_pipe.sv
// Bench for tri_area_recip_pipe: directed cases plus random triangles checked against an
// integer model of the edge function and reciprocal, with latency and handshake checks.
module tb_tri_area_recip_pipe;

  localparam int  DIV_CYC = 12 + 2*4 + 1;
  localparam longint NUM  = 64'sd1 <<< 20;
  localparam longint QMAX = 32767;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] v0x = '0, v0y = '0, v1x = '0, v1y = '0, v2x = '0, v2y = '0;
  logic [7:0]         in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [34:0] area2;
  logic signed [15:0] recip;
  logic [7:0]         out_tag;
  logic               degenerate, backface, sat;

  tri_area_recip_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .area2(area2), .recip(recip), .out_tag(out_tag),
    .degenerate(degenerate), .backface(backface), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint     area;
    longint     rcp;
    bit         deg;
    bit         bf;
    bit         sat;
    logic [7:0] tag;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen_front = 0;
  bit   chk_xfer = 0;
  bit   rnd_rdy = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input longint ax, input longint ay, input longint bx,
                                 input longint by, input longint cx, input longint cy,
                                 input logic [7:0] t);
    exp_t   r;
    longint m, q;
    r.area = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
    r.deg  = (r.area == 0);
    r.bf   = (r.area < 0);
    r.sat  = 0;
    r.rcp  = 0;
    r.tag  = t;
    r.acc  = 0;
    if (r.area != 0) begin
      m = (r.area < 0) ? -r.area : r.area;
      q = NUM / m;
      if (q > QMAX) begin
        q = QMAX;
        r.sat = 1;
      end
      r.rcp = (r.area < 0) ? -q : q;
    end
`ifdef TRI_AREA_CULL_EN
    r.deg = 0;
    r.bf  = 0;
`endif
    return r;
  endfunction

  function automatic bit culled(input exp_t e);
`ifdef TRI_AREA_CULL_EN
    return (e.area <= 0);
`else
    return (e.area != e.area);
`endif
  endfunction

  // Accept monitor: the model entry is formed from what is on the inputs at the accept edge.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      e = model(v0x, v0y, v1x, v1y, v2x, v2y, in_tag);
      e.acc = cyc;
      if (!culled(e)) exp_q.push_back(e);
    end
  end

  // Compare process: every cycle the result is presented, and the cycle after each transfer.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (chk_xfer) begin
      chk("in_ready_after_xfer", in_ready, 1);
      chk("out_valid_after_xfer", out_valid, 0);
      chk_xfer = 0;
    end
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        e = exp_q[0];
        chk("area2", area2, e.area);
        chk("recip", recip, e.rcp);
        chk("out_tag", out_tag, e.tag);
        chk("degenerate", degenerate, e.deg);
        chk("backface", backface, e.bf);
        chk("sat", sat, e.sat);
        chk("in_ready_busy", in_ready, 0);
        if (!seen_front) begin
          chk("latency", cyc - e.acc, (e.area == 0) ? 4 : 4 + DIV_CYC);
          seen_front = 1;
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen_front = 0;
          chk_xfer = 1;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(1, 0));
  end

  task automatic send(input int ax, input int ay, input int bx, input int by,
                      input int cx, input int cy, input int t);
    int n;
    v0x = 16'(ax); v0y = 16'(ay); v1x = 16'(bx); v1y = 16'(by); v2x = 16'(cx); v2y = 16'(cy);
    in_tag = 8'(t);
    in_valid = 1'b1;
    n = 0;
    @(posedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(posedge clk);
    end
    if (n >= 300) chk("accept_timeout", n, 0);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic zero_chk();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_area2", area2, 0);
    chk("rst_recip", recip, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_flags", {degenerate, backface, sat}, 0);
  endtask

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi - lo, 0)) + lo;
  endfunction

  initial begin
    exp_t e;
    int   ax, ay, kx, ky;
    // Hand-computed pins on the model itself.
    e = model(0, 0, 64, 0, 0, 32, 8'h00);
    chk("model_area_2048", e.area, 2048);
    chk("model_recip_512", e.rcp, 512);
    e = model(0, 0, 1, 0, 0, 1, 8'h00);
    chk("model_recip_sat", e.rcp, 32767);
    chk("model_sat_flag", e.sat, 1);
    e = model(0, 0, 0, 1, 1, 0, 8'h00);
    chk("model_recip_negsat", e.rcp, -32767);
    e = model(0, 0, 16, 16, 32, 32, 8'h00);
    chk("model_collinear", e.area, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_chk();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(0, 0, 64, 0, 0, 32, 8'h11);          drain();
    send(0, 0, 0, 32, 64, 0, 8'h22);          drain();
    send(0, 0, 16, 16, 32, 32, 8'h33);        drain();
    send(0, 0, 1, 0, 0, 1, 8'h44);            drain();
    send(0, 0, 0, 1, 1, 0, 8'h55);            drain();
    send(-32768, -32768, 32767, -32768, -32768, 32767, 8'h66); drain();
    send(32767, 32767, -32768, 32767, 32767, -32768, 8'h67);   drain();

    // Stall the result for 10 cycles, then release and push a second triangle straight after.
    out_ready = 1'b0;
    send(3, -5, 70, 2, -9, 40, 8'hA1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        n++;
      end
      if (n >= 100) chk("hold_timeout", n, 0);
    end
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    send(-40, 12, 25, -7, 5, 60, 8'hB2);
    drain();

    // Reset in the middle of the divide.
    send(0, 0, 64, 0, 0, 32, 8'hC3);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    seen_front = 0;
    @(posedge clk);
    @(negedge clk);
    zero_chk();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(10, 10, 90, 20, 30, 70, 8'hC4);
    drain();

    rnd_rdy = 1;
    for (int i = 0; i < 120; i++) begin
      case (rnd(0, 3))
        0: send(rnd(-3, 3), rnd(-3, 3), rnd(-3, 3), rnd(-3, 3), rnd(-3, 3), rnd(-3, 3), i);
        1: send(rnd(-200, 200), rnd(-200, 200), rnd(-200, 200), rnd(-200, 200),
                rnd(-200, 200), rnd(-200, 200), i);
        2: send(rnd(-32768, 32767), rnd(-32768, 32767), rnd(-32768, 32767),
                rnd(-32768, 32767), rnd(-32768, 32767), rnd(-32768, 32767), i);
        default: begin
          ax = rnd(-100, 100); ay = rnd(-100, 100);
          kx = rnd(-50, 50);   ky = rnd(-50, 50);
          send(ax, ay, ax + kx, ay + ky, ax + 2*kx, ay + 2*ky, i);
        end
      endcase
    end
    drain();
    rnd_rdy = 0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
